jtag_dbg_bridge: RTL and testbench

JTAG_DBG_BRIDGE -- requirements
Module: jtag_dbg_bridge

---
 rtl/dbg_pkg.sv | 36 +++
 rtl/dbg_timeout.sv | 36 +++
 rtl/jtag_dbg_bridge.sv | 184 ++++++++++++++++++
 tb/tb_jtag_dbg_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the JTAG debug bridge: command opcodes, FSM state
// encodings, status bit positions and bus constants.
// -----------------------------------------------------------------------------
package dbg_pkg;

  // Opcode carried in bits [31:30] of a command-register word.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SETADDR = 2'b01,
    OP_READ    = 2'b10,
    OP_CLRERR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Bit positions inside dbg_status.
  localparam int STAT_BUSY     = 0;
  localparam int STAT_PENDING  = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_TIMEOUT  = 3;

  localparam logic [3:0]  WEN_WORD  = 4'hF;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  // SETADDR carries a word index; the bus wants a byte address.
  function automatic logic [31:0] word_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/dbg_timeout.sv
// -----------------------------------------------------------------------------
// dbg_timeout
// Per-access watchdog. Cleared when an access is launched, counts every cycle
// the bridge sits in ACCESS and flags expiry on the count TIMEOUT-1.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_start    : an access is launched this cycle (counter restarts at 0)
//   i_run      : bridge is in ACCESS
//   o_expired  : last allowed cycle of the access
// -----------------------------------------------------------------------------
module dbg_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_start,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/jtag_dbg_bridge.sv
// -----------------------------------------------------------------------------
// jtag_dbg_bridge
// Turns words captured by the JTAG DR logic into single bus accesses.
// Command words (dbg_sel=0) set the address, start a read, clear errors or do
// nothing; data words (dbg_sel=1) start a full-word write. The address
// auto-increments after every bus access, including timed-out ones.
//   clk, rstn             : clock, asynchronous active-low reset
//   dbg_word/sel/strobe   : captured word, register select, one-cycle strobe
//   mem_addr/wdata/wen    : registered bus request fields (wen=0 is a read)
//   mem_valid/ready/rdata : bus handshake and read data
//   dbg_reply             : data of the last completed read
//   dbg_status            : {timeout_err, overflow, pending, busy}
// -----------------------------------------------------------------------------
module jtag_dbg_bridge
  import dbg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dbg_word,
  input  logic        dbg_sel,
  input  logic        dbg_strobe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wen,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dbg_reply,
  output logic [3:0]  dbg_status
);

  state_e      r_state, w_next_state;
  logic [1:0]  r_rst_sync;
  logic [31:0] r_addr;
  logic        r_pend_valid, r_pend_sel;
  logic [31:0] r_pend_word;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr, r_mem_wdata, r_reply;
  logic [3:0]  r_mem_wen;
  logic        r_timeout_err, r_overflow;

  logic        w_strobe, w_in_access, w_expired;
  logic        w_src_valid, w_src_sel, w_src_bus, w_done_acc;
  logic        w_overflow, w_capture;
  logic [31:0] w_src_word;
  op_e         w_src_op;

  // Strobes are ignored until two edges after reset release, so a half-reset
  // register file can never start a bus access.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_strobe    = dbg_strobe & r_rst_sync[1];
  assign w_in_access = (r_state == ST_ACCESS);

  // Word to execute this cycle: the pending buffer has priority; a fresh
  // strobe is only executed directly when the bridge is idle and empty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_src_valid  = 1'b0;
    w_src_sel    = r_pend_sel;
    w_src_word   = r_pend_word;
    if (!w_in_access) begin
      if (r_pend_valid) begin
        w_src_valid = 1'b1;
      end else if (r_state == ST_IDLE && w_strobe) begin
        w_src_valid = 1'b1;
        w_src_sel   = dbg_sel;
        w_src_word  = dbg_word;
      end
    end
    w_src_op   = op_e'(w_src_word[31:30]);
    w_src_bus  = w_src_valid & (w_src_sel | (w_src_op == OP_READ));
    w_done_acc = w_in_access & (mem_ready | w_expired);

    unique case (r_state)
      ST_IDLE:   if (w_src_bus) w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_done_acc) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = w_src_bus ? ST_ACCESS : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // A strobe while a word is already pending is lost; otherwise a strobe
  // outside IDLE (including the mem_ready cycle) is parked in the buffer.
  assign w_overflow = w_strobe & r_pend_valid;
  assign w_capture  = w_strobe & ~r_pend_valid & (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  dbg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .i_start  (w_src_bus),
    .i_run    (w_in_access),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_sel   <= 1'b0;
      r_pend_word  <= '0;
    end else begin
      if (w_src_valid && r_pend_valid) r_pend_valid <= 1'b0;
      if (w_capture) begin
        r_pend_valid <= 1'b1;
        r_pend_sel   <= dbg_sel;
        r_pend_word  <= dbg_word;
      end
    end
  end

  // Launch (IDLE/DONE) and completion (ACCESS) are mutually exclusive, so
  // the two blocks below never compete for the same register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr        <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wen     <= '0;
      r_reply       <= '0;
      r_timeout_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_src_valid) begin
        if (w_src_sel) begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= w_src_word;
          r_mem_wen   <= WEN_WORD;
        end else begin
          unique case (w_src_op)
            OP_SETADDR: r_addr <= word_addr(w_src_word[29:0]);
            OP_READ: begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wen   <= '0;
            end
            OP_CLRERR: begin
              r_timeout_err <= 1'b0;
              r_overflow    <= 1'b0;
            end
            default: ;
          endcase
        end
      end
      if (w_done_acc) begin
        r_mem_valid <= 1'b0;
        r_addr      <= r_addr + ADDR_STEP;
        if (mem_ready) begin
          if (r_mem_wen == '0) r_reply <= mem_rdata;
        end else begin
          r_timeout_err <= 1'b1;
        end
      end
      // Placed after CLRERR so a word lost in the same cycle stays visible.
      if (w_overflow) r_overflow <= 1'b1;
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wen   = r_mem_wen;
  assign dbg_reply = r_reply;

  assign dbg_status[STAT_BUSY]     = (r_state != ST_IDLE);
  assign dbg_status[STAT_PENDING]  = r_pend_valid;
  assign dbg_status[STAT_OVERFLOW] = r_overflow;
  assign dbg_status[STAT_TIMEOUT]  = r_timeout_err;

endmodule

// File: tb/tb_jtag_dbg_bridge.sv
// -----------------------------------------------------------------------------
// tb_jtag_dbg_bridge
// Bench for jtag_dbg_bridge (TIMEOUT=16). A bus responder answers requests
// after a programmable delay; a monitor pops the expected request from a
// queue each time mem_valid rises. Inputs change on the falling edge and
// outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_jtag_dbg_bridge;
  import dbg_pkg::*;

  localparam int TO = 16;

  logic        clk, rstn;
  logic [31:0] dbg_word;
  logic        dbg_sel, dbg_strobe;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_reply;
  logic [3:0]  mem_wen, dbg_status;
  logic        mem_valid, mem_ready;

  jtag_dbg_bridge #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .dbg_word  (dbg_word),
    .dbg_sel   (dbg_sel),
    .dbg_strobe(dbg_strobe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .dbg_reply (dbg_reply),
    .dbg_status(dbg_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } bus_exp_t;

  typedef struct {
    logic        set_addr;
    logic [29:0] arg;
    logic        is_wr;
    logic [31:0] data;
    int          delay;
    logic [31:0] exp_addr;
    logic [31:0] exp_reply;
  } vec_t;

  bus_exp_t    exp_q[$];
  bus_exp_t    mon_e;
  vec_t        vecs[7];
  int          n_cmp = 0, n_bad = 0, n_req = 0;
  int          rsp_delay, rsp_cnt;
  logic [31:0] rsp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int n);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no progress after %0d cycles", name, n);
  endtask

  function automatic logic [31:0] cmd(input op_e op, input logic [29:0] arg);
    return {op, arg};
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    exp_q.push_back('{addr: a, wdata: d, wen: w});
  endtask

  task automatic send(input logic sel, input logic [31:0] word);
    @(negedge clk);
    dbg_sel    = sel;
    dbg_word   = word;
    dbg_strobe = 1'b1;
    @(negedge clk);
    dbg_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_status[1:0] != 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail(name, n);
  endtask

  // Bus responder: raises mem_ready for one cycle after rsp_delay cycles of
  // mem_valid; a negative delay never answers.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    rsp_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_ready = 1'b0;
      if (mem_valid && rsp_delay >= 0) begin
        if (rsp_cnt >= rsp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rsp_data;
          rsp_cnt   = 0;
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every new request must match the queue head.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid && !prev) begin
        n_req++;
        check("req_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("req_addr", mem_addr, mon_e.addr);
          check("req_wen", 32'(mem_wen), 32'(mon_e.wen));
          if (mon_e.wen != 4'h0) check("req_wdata", mem_wdata, mon_e.wdata);
        end
      end
      prev = mem_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, req_before;
    rstn = 1'b0; dbg_word = '0; dbg_sel = 1'b0; dbg_strobe = 1'b0;
    rsp_delay = 0; rsp_data = '0;

    //            set  arg           wr    data          dly exp_addr       exp_reply
    vecs[0] = '{1'b1, 30'h0000100, 1'b1, 32'hDEADBEEF, 3, 32'h00000400, 32'h00000000};
    vecs[1] = '{1'b0, 30'h0,       1'b0, 32'h12345678, 1, 32'h00000404, 32'h12345678};
    vecs[2] = '{1'b0, 30'h0,       1'b0, 32'hA5A50F0F, 0, 32'h00000408, 32'hA5A50F0F};
    vecs[3] = '{1'b1, 30'h0,       1'b1, 32'h00000000, 2, 32'h00000000, 32'hA5A50F0F};
    vecs[4] = '{1'b0, 30'h0,       1'b0, 32'hCAFEF00D, 5, 32'h00000004, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 30'h3FFFFFFF,1'b1, 32'h11111111, 0, 32'hFFFFFFFC, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 30'h0,       1'b1, 32'h22222222, 1, 32'h00000000, 32'hCAFEF00D};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid",  32'(mem_valid), 32'd0);
    check("rst_addr",   mem_addr, 32'h0);
    check("rst_wdata",  mem_wdata, 32'h0);
    check("rst_wen",    32'(mem_wen), 32'h0);
    check("rst_reply",  dbg_reply, 32'h0);
    check("rst_status", 32'(dbg_status), 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven accesses: address/write, reads, auto-increment, wrap
    for (int i = 0; i < 7; i++) begin
      rsp_delay = vecs[i].delay;
      rsp_data  = vecs[i].data;
      if (vecs[i].set_addr) send(1'b0, cmd(OP_SETADDR, vecs[i].arg));
      if (vecs[i].is_wr) begin
        push(vecs[i].exp_addr, vecs[i].data, 4'hF);
        send(1'b1, vecs[i].data);
      end else begin
        push(vecs[i].exp_addr, 32'h0, 4'h0);
        send(1'b0, cmd(OP_READ, 30'h0));
      end
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_reply", i), dbg_reply, vecs[i].exp_reply);
      check($sformatf("vec%0d_status", i), 32'(dbg_status), 32'h0);
    end

    // NOP never touches the bus
    req_before = n_req;
    send(1'b0, cmd(OP_NOP, 30'h1234));
    repeat (3) @(negedge clk);
    check("nop_no_req", 32'(n_req), 32'(req_before));
    check("nop_status", 32'(dbg_status), 32'h0);

    // Timeout: 16 cycles of mem_valid, sticky error, reply kept, addr advances
    send(1'b0, cmd(OP_SETADDR, 30'h100));
    rsp_delay = -1;
    push(32'h400, 32'h0, 4'h0);
    send(1'b0, cmd(OP_READ, 30'h0));
    n = 0;
    while (mem_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("to_valid_cycles", 32'(n), 32'd16);
    wait_idle("to_idle");
    check("to_status", 32'(dbg_status), 32'h8);
    check("to_reply_kept", dbg_reply, 32'hCAFEF00D);
    rsp_delay = 0;
    rsp_data  = 32'h0BADC0DE;
    push(32'h404, 32'h0, 4'h0);
    send(1'b0, cmd(OP_READ, 30'h0));
    wait_idle("to_read2_idle");
    check("to_read2_reply", dbg_reply, 32'h0BADC0DE);
    check("to_err_sticky", 32'(dbg_status), 32'h8);
    send(1'b0, cmd(OP_CLRERR, 30'h0));
    @(negedge clk);
    check("to_clrerr", 32'(dbg_status), 32'h0);

    // Three strobes during one stalled access: 2nd queued, 3rd dropped
    send(1'b0, cmd(OP_SETADDR, 30'h200));
    rsp_delay = 6;
    push(32'h800, 32'hA0000001, 4'hF);
    send(1'b1, 32'hA0000001);
    push(32'h804, 32'hB0000002, 4'hF);
    send(1'b1, 32'hB0000002);
    check("busy_pending", 32'(dbg_status[STAT_PENDING]), 32'd1);
    send(1'b1, 32'hC0000003);
    check("busy_overflow", 32'(dbg_status[STAT_OVERFLOW]), 32'd1);
    wait_idle("busy_idle");
    check("busy_q_empty", 32'(exp_q.size()), 32'd0);
    check("busy_status", 32'(dbg_status), 32'h4);
    send(1'b0, cmd(OP_CLRERR, 30'h0));
    @(negedge clk);
    check("busy_clrerr", 32'(dbg_status), 32'h0);

    // Strobe coincident with mem_ready is queued and executed next
    rsp_delay = 3;
    push(32'h808, 32'hE0000005, 4'hF);
    send(1'b1, 32'hE0000005);
    n = 0;
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) bound_fail("coin_ready", n);
    push(32'h80C, 32'hF0000006, 4'hF);
    dbg_sel = 1'b1; dbg_word = 32'hF0000006; dbg_strobe = 1'b1;
    @(negedge clk);
    dbg_strobe = 1'b0;
    check("coin_status", 32'(dbg_status), 32'h3);
    check("coin_valid_drop", 32'(mem_valid), 32'd0);
    wait_idle("coin_idle");
    check("coin_q_empty", 32'(exp_q.size()), 32'd0);
    check("coin_final_status", 32'(dbg_status), 32'h0);

    // Pending SETADDR lands after the in-flight access's increment
    rsp_delay = 2;
    push(32'h810, 32'h60000007, 4'hF);
    send(1'b1, 32'h60000007);
    send(1'b0, cmd(OP_SETADDR, 30'h300));
    check("pset_pending", 32'(dbg_status[STAT_PENDING]), 32'd1);
    wait_idle("pset_idle");
    rsp_delay = 0;
    push(32'hC00, 32'h70000008, 4'hF);
    send(1'b1, 32'h70000008);
    wait_idle("pset_write_idle");

    // Reset in the middle of an access
    rsp_delay = -1;
    push(32'hC04, 32'h80000009, 4'hF);
    send(1'b1, 32'h80000009);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid",  32'(mem_valid), 32'd0);
    check("mid_rst_addr",   mem_addr, 32'h0);
    check("mid_rst_wdata",  mem_wdata, 32'h0);
    check("mid_rst_wen",    32'(mem_wen), 32'h0);
    check("mid_rst_reply",  dbg_reply, 32'h0);
    check("mid_rst_status", 32'(dbg_status), 32'h0);
    req_before = n_req;
    repeat (2) @(negedge clk);
    rsp_delay = 0;
    // A strobe on the first edge after release must be ignored.
    rstn = 1'b1;
    dbg_sel = 1'b1; dbg_word = 32'h9000000A; dbg_strobe = 1'b1;
    @(negedge clk);
    dbg_strobe = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_no_req", 32'(n_req), 32'(req_before));
    check("post_rst_idle", 32'(dbg_status), 32'h0);
    push(32'h0, 32'h5000000B, 4'hF);
    send(1'b1, 32'h5000000B);
    wait_idle("post_rst_write_idle");
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
